// File: rtl/instr_sequencer_if.sv
// Control bundle between the hardwired sequencer and the Phase 1 datapath:
// memory-ready handshake and IR in, bus/load/ALU strobes out.
interface instr_sequencer_if #(
    parameter int OPW = 5,
    parameter int IRW = 32
);
    logic           Run_req;
    logic           Stop;
    logic [IRW-1:0] IR;
    logic           Mem_ready;

    logic           PCout, Zlowout, MDRout;
    logic           MARin, PCin, MDRin, IRin, Yin, ZLowIn;
    logic           IncPC, Read;
    logic           Gra, Grb, Grc, Rin, Rout;
    logic [OPW-1:0] op_code;
    logic           Run;
    logic           Illegal;

    modport master (
        input  Run_req, Stop, IR, Mem_ready,
        output PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
        output IncPC, Read, Gra, Grb, Grc, Rin, Rout, op_code, Run, Illegal
    );

    modport slave (
        output Run_req, Stop, IR, Mem_ready,
        input  PCout, Zlowout, MDRout, MARin, PCin, MDRin, IRin, Yin, ZLowIn,
        input  IncPC, Read, Gra, Grb, Grc, Rin, Rout, op_code, Run, Illegal
    );
endinterface

// File: rtl/instr_sequencer.sv
// Hardwired fetch/decode/execute sequencer: one control step per clock, strobes decoded from state
// (op_code also from IR). Fetch stalls in T1W while Mem_ready is low.
module instr_sequencer #(
    parameter int OPW = 5,
    parameter int IRW = 32
) (
    input  logic                Clock,
    input  logic                Clear,
    instr_sequencer_if.master   ctl
);
    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T1W, S_T2, S_T3, S_T4, S_T5, S_HALT
    } state_t;

    state_t         state_q, state_d;
    logic           illegal_q, illegal_d;
    logic           bin_q, bin_d;

    logic [OPW-1:0] opc;
    logic           is_bin, is_una, is_nop, is_halt;
    logic           ir_unused;

    assign opc       = ctl.IR[IRW-1 -: OPW];
    assign ir_unused = ^ctl.IR[IRW-OPW-1:0];

    assign is_bin  = (opc == OPW'(0)) || (opc == OPW'(1)) || (opc == OPW'(2)) || (opc == OPW'(5));
    assign is_una  = (opc == OPW'(3)) || (opc == OPW'(4));
    assign is_nop  = (opc == OPW'(30));
    assign is_halt = (opc == OPW'(31));

    logic           pcout, zlowout, mdrout, marin, pcin, mdrin, irin, yin, zlowin;
    logic           incpc, rd, gra, grb, grc, rin, rout, run;
    logic [OPW-1:0] op;
    state_t         end_state;

    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q   <= S_IDLE;
            illegal_q <= 1'b0;
            bin_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            bin_q     <= bin_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        bin_d     = bin_q;
        pcout = 1'b0; zlowout = 1'b0; mdrout = 1'b0; marin = 1'b0; pcin = 1'b0;
        mdrin = 1'b0; irin = 1'b0; yin = 1'b0; zlowin = 1'b0; incpc = 1'b0;
        rd = 1'b0; gra = 1'b0; grb = 1'b0; grc = 1'b0; rin = 1'b0; rout = 1'b0;
        run = 1'b0;
        op  = '0;
        // Stop is only honoured at an instruction boundary and beats Run_req there.
        end_state = ctl.Stop ? S_IDLE : S_T0;

        case (state_q)
            S_IDLE: begin
                if (ctl.Run_req) state_d = S_T0;
            end
            S_T0: begin
                run = 1'b1; pcout = 1'b1; marin = 1'b1; incpc = 1'b1; zlowin = 1'b1;
                state_d = S_T1;
            end
            S_T1: begin
                run = 1'b1; zlowout = 1'b1; pcin = 1'b1; rd = 1'b1; mdrin = 1'b1;
                state_d = ctl.Mem_ready ? S_T2 : S_T1W;
            end
            S_T1W: begin
                run = 1'b1; rd = 1'b1; mdrin = 1'b1;
                if (ctl.Mem_ready) state_d = S_T2;
            end
            S_T2: begin
                run = 1'b1; mdrout = 1'b1; irin = 1'b1;
                state_d = S_T3;
            end
            S_T3: begin
                run   = 1'b1;
                bin_d = is_bin;
                if (is_bin) begin
                    grb = 1'b1; rout = 1'b1; yin = 1'b1;
                    state_d = S_T4;
                end else if (is_una) begin
                    grb = 1'b1; rout = 1'b1; zlowin = 1'b1; op = opc;
                    state_d = S_T4;
                end else if (is_nop) begin
                    state_d = end_state;
                end else if (is_halt) begin
                    state_d = S_HALT;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = S_HALT;
                end
            end
            S_T4: begin
                run = 1'b1;
                if (bin_q) begin
                    grc = 1'b1; rout = 1'b1; zlowin = 1'b1; op = opc;
                    state_d = S_T5;
                end else begin
                    zlowout = 1'b1; gra = 1'b1; rin = 1'b1;
                    state_d = end_state;
                end
            end
            S_T5: begin
                run = 1'b1; zlowout = 1'b1; gra = 1'b1; rin = 1'b1;
                state_d = end_state;
            end
            S_HALT: begin
                if (ctl.Run_req) begin
                    state_d   = S_T0;
                    illegal_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign ctl.PCout   = pcout;
    assign ctl.Zlowout = zlowout;
    assign ctl.MDRout  = mdrout;
    assign ctl.MARin   = marin;
    assign ctl.PCin    = pcin;
    assign ctl.MDRin   = mdrin;
    assign ctl.IRin    = irin;
    assign ctl.Yin     = yin;
    assign ctl.ZLowIn  = zlowin;
    assign ctl.IncPC   = incpc;
    assign ctl.Read    = rd;
    assign ctl.Gra     = gra;
    assign ctl.Grb     = grb;
    assign ctl.Grc     = grc;
    assign ctl.Rin     = rin;
    assign ctl.Rout    = rout;
    assign ctl.op_code = op;
    assign ctl.Run     = run;
    assign ctl.Illegal = illegal_q;
endmodule
